// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM-stage data port and data_mem_responder.
interface data_mem_responder_if;
  logic        DREQ;
  logic [1:0]  DRW;
  logic [31:0] DADDR;
  logic [31:0] DWDATA;
  logic [31:0] DRDATA;
  logic        DVALID;
  logic        DERR;

  modport master (output DREQ, DRW, DADDR, DWDATA, input DRDATA, DVALID, DERR);
  modport slave  (input DREQ, DRW, DADDR, DWDATA, output DRDATA, DVALID, DERR);
endinterface

// File: rtl/data_mem_responder.sv
// Two-bank word-addressed data memory with a READ_LAT-deep read response pipeline
// and one-cycle DVALID/DERR strobes for read responses and illegal requests.
module data_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  data_mem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int HI_W  = 32 - ADDR_W - 2;

  generate
    if (READ_LAT < 1 || READ_LAT > 3) begin : g_bad_read_lat
      $error("data_mem_responder: READ_LAT must be in 1..3");
    end
  endgenerate

  logic [31:0] bank0_mem [DEPTH];
  logic [31:0] bank1_mem [DEPTH];

  logic [ADDR_W-1:0] idx_s;
  logic              legal_s;
  logic              is_read_s;
  logic              wr_en0_s;
  logic              wr_en1_s;
  logic [31:0]       rd_word_s;

  // Stage READ_LAT-1 is the output register stage.
  logic [READ_LAT-1:0]        stage_rsp_q, stage_rsp_d;
  logic [READ_LAT-1:0]        stage_err_q, stage_err_d;
  logic [READ_LAT-1:0][31:0]  stage_data_q, stage_data_d;
  logic [READ_LAT-1:0][31:0]  shift_data_s;

  // Request decode: upper address bits must be clear, so nothing aliases into the banks.
  always_comb begin
    idx_s     = bus.DADDR[ADDR_W+1:2];
    legal_s   = (bus.DADDR[1:0] == 2'b00) && (bus.DADDR[31:ADDR_W+2] == {HI_W{1'b0}});
    is_read_s = bus.DRW[1];
    wr_en0_s  = bus.DREQ && !is_read_s && legal_s && !bus.DRW[0];
    wr_en1_s  = bus.DREQ && !is_read_s && legal_s && bus.DRW[0];
    if (legal_s) begin
      rd_word_s = bus.DRW[0] ? bank1_mem[idx_s] : bank0_mem[idx_s];
    end else begin
      rd_word_s = 32'h0000_0000;
    end
  end

  // Bank storage; intentionally not reset.
  always_ff @(posedge CLK) begin
    if (wr_en0_s) begin
      bank0_mem[idx_s] <= bus.DWDATA;
    end
    if (wr_en1_s) begin
      bank1_mem[idx_s] <= bus.DWDATA;
    end
  end

  // Response pipeline next state; the output stage keeps its data when nothing retires.
  always_comb begin
    stage_rsp_d     = '0;
    stage_err_d     = '0;
    shift_data_s    = '0;
    stage_rsp_d[0]  = bus.DREQ && is_read_s;
    stage_err_d[0]  = bus.DREQ && !legal_s;
    shift_data_s[0] = rd_word_s;
    for (int k = 1; k < READ_LAT; k++) begin
      stage_rsp_d[k]  = stage_rsp_q[k-1];
      stage_err_d[k]  = stage_err_q[k-1];
      shift_data_s[k] = stage_data_q[k-1];
    end
    stage_data_d = shift_data_s;
    stage_data_d[READ_LAT-1] = stage_rsp_d[READ_LAT-1] ? shift_data_s[READ_LAT-1]
                                                       : stage_data_q[READ_LAT-1];
  end

  // Pipeline registers; reset drops any in-flight response.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stage_rsp_q  <= '0;
      stage_err_q  <= '0;
      stage_data_q <= '0;
    end else begin
      stage_rsp_q  <= stage_rsp_d;
      stage_err_q  <= stage_err_d;
      stage_data_q <= stage_data_d;
    end
  end

  assign bus.DVALID = stage_rsp_q[READ_LAT-1];
  assign bus.DERR   = stage_err_q[READ_LAT-1];
  assign bus.DRDATA = stage_data_q[READ_LAT-1];
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with READ_LAT = 1, 2 and 3 instances.
module tb_data_mem_responder;
  logic CLK;
  logic RESET_N;
  int   total;
  int   bad;

  data_mem_responder_if b1 ();
  data_mem_responder_if b2 ();
  data_mem_responder_if b3 ();

  data_mem_responder #(.ADDR_W(10), .READ_LAT(1)) u_lat1 (.CLK(CLK), .RESET_N(RESET_N), .bus(b1));
  data_mem_responder #(.ADDR_W(10), .READ_LAT(2)) u_lat2 (.CLK(CLK), .RESET_N(RESET_N), .bus(b2));
  data_mem_responder #(.ADDR_W(10), .READ_LAT(3)) u_lat3 (.CLK(CLK), .RESET_N(RESET_N), .bus(b3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic drive1(input logic req, input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] wd);
    b1.DREQ = req; b1.DRW = rw; b1.DADDR = addr; b1.DWDATA = wd;
    @(negedge CLK);
  endtask

  task automatic drive2(input logic req, input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] wd);
    b2.DREQ = req; b2.DRW = rw; b2.DADDR = addr; b2.DWDATA = wd;
    @(negedge CLK);
  endtask

  task automatic drive3(input logic req, input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] wd);
    b3.DREQ = req; b3.DRW = rw; b3.DADDR = addr; b3.DWDATA = wd;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    b1.DREQ = 1'bx; b1.DRW = 2'bxx; b1.DADDR = 32'hxxxx_xxxx; b1.DWDATA = 32'hxxxx_xxxx;
    #1;
    total++; if (b1.DRDATA !== 32'h0) begin bad++; $display("FAIL rst_drdata: got %h want 0", b1.DRDATA); end
    total++; if (b1.DVALID !== 1'b0) begin bad++; $display("FAIL rst_dvalid: got %b want 0", b1.DVALID); end
    total++; if (b1.DERR !== 1'b0) begin bad++; $display("FAIL rst_derr: got %b want 0", b1.DERR); end
    total++; if (b3.DVALID !== 1'b0) begin bad++; $display("FAIL rst_dvalid_lat3: got %b want 0", b3.DVALID); end
    @(negedge CLK);
    b1.DREQ = 1'b0; b1.DRW = 2'b00; b1.DADDR = 32'h0; b1.DWDATA = 32'h0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_write_read;
    drive1(1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF);
    total++; if (b1.DVALID !== 1'b0) begin bad++; $display("FAIL wr_no_valid: got %b want 0", b1.DVALID); end
    total++; if (b1.DERR !== 1'b0) begin bad++; $display("FAIL wr_no_err: got %b want 0", b1.DERR); end
    drive1(1'b1, 2'b10, 32'h10, 32'h0);
    total++; if (b1.DVALID !== 1'b1) begin bad++; $display("FAIL rd_valid: got %b want 1", b1.DVALID); end
    total++; if (b1.DRDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", b1.DRDATA); end
    drive1(1'b0, 2'b10, 32'h10, 32'h0);
    total++; if (b1.DVALID !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", b1.DVALID); end
    total++; if (b1.DRDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL hold_data: got %h want deadbeef", b1.DRDATA); end
  endtask

  task automatic test_banks;
    drive1(1'b1, 2'b00, 32'h20, 32'h0000_1111);
    drive1(1'b1, 2'b01, 32'h20, 32'h0000_2222);
    drive1(1'b1, 2'b10, 32'h20, 32'h0);
    total++; if (b1.DVALID !== 1'b1) begin bad++; $display("FAIL bank0_valid: got %b want 1", b1.DVALID); end
    total++; if (b1.DRDATA !== 32'h0000_1111) begin bad++; $display("FAIL bank0_data: got %h want 00001111", b1.DRDATA); end
    drive1(1'b1, 2'b11, 32'h20, 32'h0);
    total++; if (b1.DVALID !== 1'b1) begin bad++; $display("FAIL bank1_valid: got %b want 1", b1.DVALID); end
    total++; if (b1.DRDATA !== 32'h0000_2222) begin bad++; $display("FAIL bank1_data: got %h want 00002222", b1.DRDATA); end
    drive1(1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_errors;
    drive1(1'b1, 2'b00, 32'h0, 32'hA5A5_A5A5);
    drive1(1'b1, 2'b10, 32'h13, 32'h0);
    total++; if (b1.DVALID !== 1'b1) begin bad++; $display("FAIL misrd_valid: got %b want 1", b1.DVALID); end
    total++; if (b1.DERR !== 1'b1) begin bad++; $display("FAIL misrd_err: got %b want 1", b1.DERR); end
    total++; if (b1.DRDATA !== 32'h0) begin bad++; $display("FAIL misrd_data: got %h want 0", b1.DRDATA); end
    drive1(1'b1, 2'b00, 32'h1000, 32'hBAD0_BAD0);
    total++; if (b1.DERR !== 1'b1) begin bad++; $display("FAIL oorwr_err: got %b want 1", b1.DERR); end
    total++; if (b1.DVALID !== 1'b0) begin bad++; $display("FAIL oorwr_valid: got %b want 0", b1.DVALID); end
    drive1(1'b1, 2'b10, 32'h0, 32'h0);
    total++; if (b1.DRDATA !== 32'hA5A5_A5A5) begin bad++; $display("FAIL no_alias: got %h want a5a5a5a5", b1.DRDATA); end
    total++; if (b1.DERR !== 1'b0) begin bad++; $display("FAIL good_rd_err: got %b want 0", b1.DERR); end
    drive1(1'b1, 2'b01, 32'hFFC, 32'h0F0F_0F0F);
    drive1(1'b1, 2'b11, 32'hFFC, 32'h0);
    total++; if (b1.DRDATA !== 32'h0F0F_0F0F) begin bad++; $display("FAIL top_word: got %h want 0f0f0f0f", b1.DRDATA); end
    total++; if (b1.DERR !== 1'b0) begin bad++; $display("FAIL top_word_err: got %b want 0", b1.DERR); end
    drive1(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (b1.DERR !== 1'b0) begin bad++; $display("FAIL idle_err: got %b want 0", b1.DERR); end
  endtask

  task automatic test_back_to_back;
    drive3(1'b1, 2'b00, 32'h0, 32'h0000_0100);
    drive3(1'b1, 2'b00, 32'h4, 32'h0000_0104);
    drive3(1'b1, 2'b00, 32'h8, 32'h0000_0108);
    drive3(1'b0, 2'b00, 32'h0, 32'h0);
    drive3(1'b0, 2'b00, 32'h0, 32'h0);
    drive3(1'b1, 2'b10, 32'h0, 32'h0);
    total++; if (b3.DVALID !== 1'b0) begin bad++; $display("FAIL b2b_early0: got %b want 0", b3.DVALID); end
    drive3(1'b1, 2'b10, 32'h4, 32'h0);
    total++; if (b3.DVALID !== 1'b0) begin bad++; $display("FAIL b2b_early1: got %b want 0", b3.DVALID); end
    drive3(1'b1, 2'b10, 32'h8, 32'h0);
    total++; if (b3.DVALID !== 1'b1 || b3.DRDATA !== 32'h0000_0100) begin bad++; $display("FAIL b2b_rsp0: got v=%b d=%h want v=1 d=00000100", b3.DVALID, b3.DRDATA); end
    drive3(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (b3.DVALID !== 1'b1 || b3.DRDATA !== 32'h0000_0104) begin bad++; $display("FAIL b2b_rsp1: got v=%b d=%h want v=1 d=00000104", b3.DVALID, b3.DRDATA); end
    drive3(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (b3.DVALID !== 1'b1 || b3.DRDATA !== 32'h0000_0108) begin bad++; $display("FAIL b2b_rsp2: got v=%b d=%h want v=1 d=00000108", b3.DVALID, b3.DRDATA); end
    drive3(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (b3.DVALID !== 1'b0 || b3.DRDATA !== 32'h0000_0108) begin bad++; $display("FAIL b2b_tail: got v=%b d=%h want v=0 d=00000108", b3.DVALID, b3.DRDATA); end
  endtask

  task automatic test_reset_flush;
    int vcount;
    drive2(1'b1, 2'b01, 32'h40, 32'hCAFE_F00D);
    drive2(1'b1, 2'b00, 32'h44, 32'h1234_5678);
    drive2(1'b1, 2'b11, 32'h40, 32'h0);
    b2.DREQ = 1'b0;
    total++; if (b2.DVALID !== 1'b0) begin bad++; $display("FAIL flush_early: got %b want 0", b2.DVALID); end
    RESET_N = 1'b0;
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (b2.DVALID !== 1'b0) vcount++;
    end
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (b2.DVALID !== 1'b0) vcount++;
    end
    total++; if (vcount !== 0) begin bad++; $display("FAIL flush_dropped: got %0d strobes want 0", vcount); end
    drive2(1'b1, 2'b11, 32'h40, 32'h0);
    drive2(1'b1, 2'b10, 32'h44, 32'h0);
    total++; if (b2.DVALID !== 1'b1 || b2.DRDATA !== 32'hCAFE_F00D) begin bad++; $display("FAIL flush_keep1: got v=%b d=%h want v=1 d=cafef00d", b2.DVALID, b2.DRDATA); end
    drive2(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (b2.DVALID !== 1'b1 || b2.DRDATA !== 32'h1234_5678) begin bad++; $display("FAIL flush_keep0: got v=%b d=%h want v=1 d=12345678", b2.DVALID, b2.DRDATA); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    b2.DREQ = 1'b0; b2.DRW = 2'b00; b2.DADDR = 32'h0; b2.DWDATA = 32'h0;
    b3.DREQ = 1'b0; b3.DRW = 2'b00; b3.DADDR = 32'h0; b3.DWDATA = 32'h0;
    test_reset();
    test_write_read();
    test_banks();
    test_errors();
    test_back_to_back();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
